// File: rtl/seven_seg_scan_driver_pkg.sv
// seg_pkg: shared types, constants and the nibble-to-segment decode used
// by the seven-segment scan driver and its BCD converter.
package seg_pkg;

    // Conversion FSM of the sequential double-dabble.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } bcd_state_e;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b1000000;   // segment g only
    localparam int         MAX_MS   = 9999;         // largest displayable value

    // Hex to 7-segment, seg[0]=a .. seg[6]=g, active-high.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Bus between the timer core side and the display driver.
//   value/load      : binary result and its one-cycle strobe
//   err/blank/lz_blank : display mode levels
//   seg/an          : segment bus (active-high) and anodes (active-low)
//   busy/done       : conversion status and commit pulse
interface seven_seg_scan_driver_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] value;
    logic             load;
    logic             err;
    logic             blank;
    logic             lz_blank;
    logic [6:0]       seg;
    logic [3:0]       an;
    logic             busy;
    logic             done;

    modport master (
        output value, load, err, blank, lz_blank,
        input  seg, an, busy, done
    );

    modport slave (
        input  value, load, err, blank, lz_blank,
        output seg, an, busy, done
    );
endinterface

// File: rtl/seven_seg_scan_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per clock.
//   start   : begin a conversion of bin_in; restarts (aborts) if already busy
//   busy    : conversion in progress (SHIFT or COMMIT)
//   commit  : high in the COMMIT cycle; bcd holds the finished result then
//   done    : registered pulse in the cycle after COMMIT
//   bcd     : 4-digit BCD accumulator
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             commit,
    output logic             done,
    output logic [15:0]      bcd
);
    localparam int IW = $clog2(BIN_W) + 1;

    bcd_state_e       state_reg;
    logic [15:0]      bcd_reg;
    logic [BIN_W-1:0] bin_reg;
    logic [IW-1:0]    iter_reg;
    logic             done_reg;
    logic [15:0]      bcd_adj;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            iter_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            // A commit always completes, even if a new start arrives with it.
            done_reg <= (state_reg == ST_COMMIT);
            if (start) begin
                bin_reg   <= bin_in;
                bcd_reg   <= '0;
                iter_reg  <= '0;
                state_reg <= ST_SHIFT;
            end else begin
                case (state_reg)
                    ST_SHIFT: begin
                        {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                        iter_reg           <= iter_reg + IW'(1);
                        if (iter_reg == IW'(BIN_W - 1))
                            state_reg <= ST_COMMIT;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign commit = (state_reg == ST_COMMIT);
    assign done   = done_reg;
    assign bcd    = bcd_reg;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: converts a binary millisecond result to BCD and
// time-multiplexes the four digits onto one 7-segment bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seven_seg_scan_driver_if (value/load in,
//                err/blank/lz_blank in, seg/an/busy/done out)
module seven_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 12500,
    parameter int BIN_W    = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_seg_scan_driver_if.slave bus
);
    localparam int               SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(MAX_MS);

    logic [BIN_W-1:0] sat_value;
    logic             conv_commit;
    logic [15:0]      conv_bcd;
    logic [15:0]      disp_bcd_reg;
    logic [SW-1:0]    scan_cnt_reg;
    logic [1:0]       dig_idx_reg;
    logic [6:0]       seg_reg, seg_next;
    logic [3:0]       an_reg, an_next;
    logic [3:0]       lz_dark;
    logic [3:0]       cur_nib;

    assign sat_value = (bus.value > MAX_VAL) ? MAX_VAL : bus.value;

    bin2bcd_seq #(.BIN_W(BIN_W)) u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (bus.load),
        .bin_in (sat_value),
        .busy   (bus.busy),
        .commit (conv_commit),
        .done   (bus.done),
        .bcd    (conv_bcd)
    );

    // Display register only moves on a completed conversion, so the
    // scanned digits never show a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_bcd_reg <= '0;
        else if (conv_commit)
            disp_bcd_reg <= conv_bcd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            dig_idx_reg  <= '0;
        end else if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            dig_idx_reg  <= dig_idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SW'(1);
        end
    end

    // Digit k is a leading zero when it and every higher nibble are zero.
    // Digit 0 is never suppressed.
    assign lz_dark[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign lz_dark[gi] = (disp_bcd_reg[15:gi*4] == '0);
        end
    endgenerate

    assign cur_nib = disp_bcd_reg[{dig_idx_reg, 2'b00} +: 4];

    always_comb begin
        seg_next = SEG_OFF;
        an_next  = ~(4'b0001 << dig_idx_reg);
        if (bus.blank) begin
            an_next  = 4'b1111;
            seg_next = SEG_OFF;
        end else if (bus.err) begin
            seg_next = SEG_DASH;
        end else if (bus.lz_blank && lz_dark[dig_idx_reg]) begin
            seg_next = SEG_OFF;
        end else begin
            seg_next = seg_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            an_reg  <= 4'b1111;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg = seg_reg;
    assign bus.an  = an_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
    localparam int SD    = 4;
    localparam int BIN_W = 14;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.BIN_W(BIN_W)) bus ();

    seven_seg_scan_driver #(.SCAN_DIV(SD), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Called on a negedge; load is sampled at the next posedge (E0) and
    // the task returns on the negedge right after E0.
    task automatic do_load(input logic [BIN_W-1:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        $display("load value=%0d", v);
    endtask

    // Starts on the negedge after E0 (sample n=1).
    task automatic run_conv(input string tag);
        int busy_n = 0, done_n = 0, done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin done_n++; done_at = n; end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_n, 15);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_at"}, done_at, 16);
    endtask

    // One full refresh; records each digit's segments from the one-cold anode.
    task automatic check_disp(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [7:0] got [4];
        logic [7:0] exp [4];
        exp[0] = {1'b0, e0}; exp[1] = {1'b0, e1}; exp[2] = {1'b0, e2}; exp[3] = {1'b0, e3};
        for (int k = 0; k < 4; k++) got[k] = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 4*SD; i++) begin
            case (bus.an)
                4'b1110: got[0] = {1'b0, bus.seg};
                4'b1101: got[1] = {1'b0, bus.seg};
                4'b1011: got[2] = {1'b0, bus.seg};
                4'b0111: got[3] = {1'b0, bus.seg};
                default: ;
            endcase
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_dig%0d", tag, k), got[k], exp[k]);
        $display("display %s: %h %h %h %h", tag, got[3], got[2], got[1], got[0]);
    endtask

    initial begin
        logic [3:0] an_seq [4];
        int gap_done;
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;

        rst_n = 1'b0;
        bus.value = '0; bus.load = 1'b0; bus.err = 1'b0; bus.blank = 1'b0; bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 4'b1111);
        check("rst_seg", bus.seg, 7'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;

        // Scan order after reset: each anode lit SD cycles, all showing "0".
        for (int i = 0; i < 4*SD; i++) begin
            @(negedge clk);
            check($sformatf("scan_an_%0d", i), bus.an, an_seq[i/SD]);
            if (i % SD == 0) check($sformatf("scan_seg_%0d", i), bus.seg, 7'h3F);
        end
        $display("scan order after reset observed");

        do_load(14'd347);
        run_conv("c347");
        check_disp("347", 7'h07, 7'h66, 7'h4F, 7'h3F);
        bus.lz_blank = 1'b1;
        check_disp("347_lz", 7'h07, 7'h66, 7'h4F, 7'h00);
        bus.lz_blank = 1'b0;

        do_load(14'd12000);
        run_conv("c12000");
        check_disp("sat", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        bus.lz_blank = 1'b1;
        do_load(14'd0);
        run_conv("c0");
        check_disp("zero_lz", 7'h3F, 7'h00, 7'h00, 7'h00);
        bus.lz_blank = 1'b0;

        // Abort: second load five cycles after the first wins.
        do_load(14'd1234);
        gap_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) gap_done++;
            @(negedge clk);
        end
        if (bus.done) gap_done++;
        do_load(14'd56);
        check("abort_no_done", gap_done, 0);
        run_conv("c56");
        check_disp("0056", 7'h7D, 7'h6D, 7'h3F, 7'h3F);

        bus.err = 1'b1;
        check_disp("err", 7'h40, 7'h40, 7'h40, 7'h40);
        bus.blank = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2*SD; i++) begin
            @(negedge clk);
            if (i % SD == 0) begin
                check($sformatf("blank_an_%0d", i), bus.an, 4'b1111);
                check($sformatf("blank_seg_%0d", i), bus.seg, 7'h00);
            end
        end
        bus.blank = 1'b0;
        bus.err   = 1'b0;
        check_disp("unblank", 7'h7D, 7'h6D, 7'h3F, 7'h3F);

        // Reset during SHIFT discards the conversion.
        do_load(14'd1234);
        repeat (3) @(negedge clk);
        check("mid_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_an", bus.an, 4'b1111);
        check("mrst_seg", bus.seg, 7'h00);
        check("mrst_busy", bus.busy, 1'b0);
        check("mrst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        gap_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) gap_done++;
            @(negedge clk);
        end
        check("mrst_no_done", gap_done, 0);
        check_disp("mrst_zero", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Display back end of the reaction-time tester, directly downstream of the timer core. It accepts a binary millisecond result on a one-cycle load strobe and converts it to four BCD digits with a sequential double-dabble. It then time-multiplexes the digits onto one shared 7-segment bus with per-digit anode enables, which the top level maps to `uo_out[6:0]` and `uio_out[3:0]`.

## Interface
- `SCAN_DIV`, 12500: clock cycles each digit stays lit (≥2).
- `BIN_W`, 14: width of binary input.
- `clk  input  1`: system clock.
- `rst_n  input  1`: asynchronous, active-low reset.
- `value  input  BIN_W`: binary result in ms.
- `load  input  1`: one-cycle strobe; `value` is sampled when high.
- `err  input  1`: level; show "----" (false start / timeout).
- `blank  input  1`: level; all anodes off.
- `lz_blank  input  1`: level; suppress leading zeros (digit 0 always shown).
- `seg  output  7`: segments a..g, `seg[0]`=a, active-high, registered.
- `an  output  4`: anodes, active-low, `an[0]`=least-significant digit, registered.
- `busy  output  1`: conversion in progress.
- `done  output  1`: one-cycle pulse when a new value is committed to display.

## Operation
- Input saturation: `value` > 9999 is captured as 9999.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE + `load`: capture the saturated value, clear the BCD accumulator, iter=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After the BIN_W-th shift, go to COMMIT.
  - COMMIT: copy the accumulator to the 16-bit display register `disp_bcd`, pulse `done`, go to IDLE.
- `load` while in SHIFT or COMMIT: abort and restart with the new value (last wins). An aborted conversion never reaches `disp_bcd`, and no `done` pulse is issued for it.
- Scanning is independent of the FSM:
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - On wrap, `dig_idx` increments mod 4 (3→0).
- Per-digit segment selection, in priority order:
  - `blank`: `an`=1111 and `seg`=0.
  - `err`: `seg`=7'b1000000 (g only) on the selected digit.
  - `lz_blank`: digit k>0 is dark (`seg`=0, its anode still driven) when all nibbles ≥k are zero.
  - Otherwise: standard hex-to-7seg decode of the nibble; BCD nibbles never exceed 9.
- `an` = one-cold of `dig_idx`.
- `disp_bcd` changes only in COMMIT, so a display update is atomic.

## Timing
- Reset values:
  - `seg`=0, `an`=1111, `busy`=0, `done`=0.
  - `disp_bcd`=0, `scan_cnt`=0, `dig_idx`=0, FSM=IDLE.
- Reset is asynchronous assert; deassertion is synchronized by the top level. Reset mid-conversion discards the conversion.
- `load` sampled at edge E0:
  - `busy` is high after E0 through E(BIN_W+1).
  - `disp_bcd` is valid after E(BIN_W+1), i.e. 15 cycles at default.
  - `done` is high for exactly the cycle following E(BIN_W+1).
- `seg`/`an` lag `dig_idx`/`disp_bcd`/`err`/`blank`/`lz_blank` by one register stage.
- Each digit stays lit for exactly SCAN_DIV cycles; full refresh is 4·SCAN_DIV cycles.
- `load` and COMMIT in the same cycle: the commit completes, `done` pulses, and the new conversion starts.

## Structure
- Package `seg_pkg` holds:
  - FSM state enum.
  - Constants `SEG_OFF`, `SEG_DASH`, `MAX_MS`=9999.
  - `function` for nibble→7seg decode.
- Sub-module `bin2bcd_seq` owns the double-dabble datapath, `start`/`busy`/`done` and the abort-on-start behaviour.
- The top of this block owns saturation, `disp_bcd`, the scan counter and the output registers.

## Test plan
- Reset with `rst_n`=0 → `an`=1111, `seg`=0, `busy`=0. After release with SCAN_DIV=4 → `an` cycles 1110, 1101, 1011, 0111 every 4 cycles, all showing "0" (7'b0111111).
- `load` with `value`=347 → `busy` high for 15 cycles, then `done` pulse. Digits decode 7, 4, 3, 0. With `lz_blank`=1 the digit-3 `seg`=0.
- `load` with `value`=12000 → displays 9999. `value`=0 with `lz_blank`=1 → only digit 0 lit, showing "0".
- `load` 1234, then `load` 56 five cycles later → no `done` for 1234. `done` comes 15 cycles after the second load, and the display shows 0056.
- `err`=1 → every digit `seg`=7'b1000000. Then `blank`=1 as well → `an`=1111. `blank` deasserted → scan resumes with no change to `disp_bcd`.
- Reset asserted during SHIFT → outputs return to reset values immediately, `disp_bcd`=0, and no `done` pulse.
